// File: rtl/free_index_pool.sv
// Free-entry bitmap allocator: prefetches the highest free index into a hold register.
// Optional FREE_INDEX_POOL_STATS_EN adds allocation/double-free/low-water statistics.
module free_index_pool #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             alloc_valid,
    input  logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_index,
    input  logic             free_valid,
    input  logic [IDX_W-1:0] free_index,
    input  logic             flush,
    output logic             err_double_free,
    output logic [IDX_W:0]   num_free,
    output logic             empty
`ifdef FREE_INDEX_POOL_STATS_EN
    ,
    output logic [31:0]      stat_alloc_cnt,
    output logic [31:0]      stat_dfree_cnt,
    output logic [IDX_W:0]   stat_min_free
`endif
);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] bitmap_q, bitmap_d;
    logic [NUM_ENTRIES-1:0] rel_mask, pick_mask;
    logic [IDX_W-1:0]       hold_q, hold_d, pick_idx;
    logic [IDX_W:0]         cnt_d;
    logic                   any_free, xfer, in_range, bit_set, hold_hit;
    logic                   dfree, rel_ok, err_d, empty_d;

    // Highest set bit wins: later iterations overwrite lower hits.
    always_comb begin
        pick_idx  = '0;
        pick_mask = '0;
        rel_mask  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (bitmap_q[i]) pick_idx = IDX_W'(i);
            rel_mask[i] = (free_index == IDX_W'(i));
        end
        for (int i = 0; i < NUM_ENTRIES; i++)
            pick_mask[i] = any_free && (pick_idx == IDX_W'(i));
    end

    assign any_free = |bitmap_q;
    assign xfer     = (state_q == S_HOLD) && alloc_ready;
    assign in_range = |rel_mask;
    assign bit_set  = |(rel_mask & bitmap_q);
    assign hold_hit = (state_q == S_HOLD) && !xfer && (free_index == hold_q);
    assign dfree    = free_valid && (!in_range || bit_set || hold_hit);
    assign rel_ok   = free_valid && !dfree;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        bitmap_d = bitmap_q;
        err_d    = 1'b0;
        if (flush) begin
            bitmap_d = {NUM_ENTRIES{1'b1}};
            state_d  = S_EMPTY;
        end else begin
            err_d = dfree;
            unique case (state_q)
                S_EMPTY: begin
                    if (any_free) begin
                        state_d  = S_HOLD;
                        hold_d   = pick_idx;
                        bitmap_d = bitmap_d & ~pick_mask;
                    end
                end
                S_HOLD: begin
                    if (xfer && any_free) begin
                        hold_d   = pick_idx;
                        bitmap_d = bitmap_d & ~pick_mask;
                    end else if (xfer) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
            // Reload picks from the pre-release bitmap; release lands alongside.
            if (rel_ok) bitmap_d = bitmap_d | rel_mask;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            cnt_d = cnt_d + (IDX_W+1)'(bitmap_d[i]);
    end

    assign empty_d = (state_d == S_EMPTY) && (bitmap_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_EMPTY;
            bitmap_q        <= {NUM_ENTRIES{1'b1}};
            hold_q          <= '0;
            err_double_free <= 1'b0;
            num_free        <= (IDX_W+1)'(NUM_ENTRIES);
            empty           <= 1'b0;
        end else begin
            state_q         <= state_d;
            bitmap_q        <= bitmap_d;
            hold_q          <= hold_d;
            err_double_free <= err_d;
            num_free        <= cnt_d;
            empty           <= empty_d;
        end
    end

    assign alloc_valid = (state_q == S_HOLD);
    assign alloc_index = hold_q;

`ifdef FREE_INDEX_POOL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_cnt <= '0;
            stat_dfree_cnt <= '0;
            stat_min_free  <= (IDX_W+1)'(NUM_ENTRIES);
        end else begin
            if (xfer && !flush && stat_alloc_cnt != '1)
                stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
            if (dfree && !flush && stat_dfree_cnt != '1)
                stat_dfree_cnt <= stat_dfree_cnt + 32'd1;
            if (flush)
                stat_min_free <= (IDX_W+1)'(NUM_ENTRIES);
            else if (cnt_d < stat_min_free)
                stat_min_free <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_free_index_pool.sv
// Bench for free_index_pool: directed scenarios plus randomized traffic
// checked every cycle against a set-based reference model.
module tb_free_index_pool;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [W-1:0] alloc_index;
    logic         free_valid;
    logic [W-1:0] free_index;
    logic         flush;
    logic         err_double_free;
    logic [W:0]   num_free;
    logic         empty;

    free_index_pool #(.NUM_ENTRIES(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_index     (alloc_index),
        .free_valid      (free_valid),
        .free_index      (free_index),
        .flush           (flush),
        .err_double_free (err_double_free),
        .num_free        (num_free),
        .empty           (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 0;

    // Model: which indices are free, and what (if anything) is reserved.
    bit m_free[N];
    bit m_hv;
    int m_hidx;
    bit m_err;
    int m_nfree;
    bit m_empty;

    bit x_free[N];
    bit x_hv;
    int x_hidx;
    bit x_err;
    int x_nfree;
    bit x_empty;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        m_hv    = 1'b0;
        m_hidx  = 0;
        m_err   = 1'b0;
        m_nfree = N;
        m_empty = 1'b0;
    endtask

    task automatic model_next();
        bit xfer;
        bit dbl;
        int fi;
        int best;
        x_free = m_free;
        x_hv   = m_hv;
        x_hidx = m_hidx;
        x_err  = 1'b0;
        if (flush) begin
            for (int i = 0; i < N; i++) x_free[i] = 1'b1;
            x_hv = 1'b0;
        end else begin
            xfer = m_hv && alloc_ready;
            fi   = int'(free_index);
            dbl  = free_valid &&
                   (fi >= N || m_free[fi] || (m_hv && !xfer && fi == m_hidx));
            x_err = dbl;
            if (!m_hv || xfer) begin
                best = -1;
                for (int i = 0; i < N; i++) if (m_free[i]) best = i;
                if (best >= 0) begin
                    x_hv         = 1'b1;
                    x_hidx       = best;
                    x_free[best] = 1'b0;
                end else begin
                    x_hv = 1'b0;
                end
            end
            if (free_valid && !dbl) x_free[fi] = 1'b1;
        end
        x_nfree = 0;
        for (int i = 0; i < N; i++) x_nfree += int'(x_free[i]);
        x_empty = !x_hv && (x_nfree == 0);
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_free  = x_free;
        m_hv    = x_hv;
        m_hidx  = x_hidx;
        m_err   = x_err;
        m_nfree = x_nfree;
        m_empty = x_empty;
        #2;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        free_index  = '0;
        flush       = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("alloc_valid", alloc_valid, m_hv);
                if (m_hv) check("alloc_index", alloc_index, m_hidx);
                check("err_double_free", err_double_free, m_err);
                check("num_free", num_free, m_nfree);
                check("empty", empty, m_empty);
            end
        end
    end

    initial begin
        do_reset();
        chk_en = 1;
        check("rst_valid", alloc_valid, 0);
        check("rst_index", alloc_index, 0);
        check("rst_err", err_double_free, 0);
        check("rst_nfree", num_free, 8);
        check("rst_empty", empty, 0);

        // Drain the pool back-to-back.
        rst_n       = 1'b1;
        alloc_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drain_valid", alloc_valid, 1);
            check("drain_idx", alloc_index, 7 - k);
        end
        tick();
        check("drained_valid", alloc_valid, 0);
        check("drained_empty", empty, 1);
        check("drained_nfree", num_free, 0);
        alloc_ready = 1'b0;

        // Release into an exhausted pool: regrant two cycles later.
        free_valid = 1'b1;
        free_index = 3'd3;
        tick();
        free_valid = 1'b0;
        check("rel3_err", err_double_free, 0);
        check("rel3_valid_early", alloc_valid, 0);
        tick();
        check("rel3_valid", alloc_valid, 1);
        check("rel3_idx", alloc_index, 3);
        check("rel3_err2", err_double_free, 0);

        // Releasing the held index is a double free.
        do_reset();
        rst_n = 1'b1;
        tick();
        check("hold7_idx", alloc_index, 7);
        check("hold7_nfree", num_free, 7);
        free_valid = 1'b1;
        free_index = 3'd7;
        tick();
        free_valid = 1'b0;
        check("dfree7_err", err_double_free, 1);
        check("dfree7_nfree", num_free, 7);
        tick();
        check("dfree7_pulse", err_double_free, 0);

        // Releasing an already free index.
        free_valid = 1'b1;
        free_index = 3'd5;
        tick();
        free_valid = 1'b0;
        check("dfree5_err", err_double_free, 1);
        check("dfree5_nfree", num_free, 7);
        tick();

        // Transfer and release the same index in one cycle.
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
        check("hold6_idx", alloc_index, 6);
        check("hold6_nfree", num_free, 6);
        alloc_ready = 1'b1;
        free_valid  = 1'b1;
        free_index  = 3'd6;
        tick();
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        check("xrel6_err", err_double_free, 0);
        check("xrel6_idx", alloc_index, 5);
        check("xrel6_nfree", num_free, 6);
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
        check("regrant6_valid", alloc_valid, 1);
        check("regrant6_idx", alloc_index, 6);

        // Flush with a concurrent release and transfer.
        do_reset();
        rst_n       = 1'b1;
        alloc_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("pre_flush_idx", alloc_index, 3);
        flush      = 1'b1;
        free_valid = 1'b1;
        free_index = 3'd7;
        tick();
        flush       = 1'b0;
        free_valid  = 1'b0;
        alloc_ready = 1'b0;
        check("flush_valid", alloc_valid, 0);
        check("flush_nfree", num_free, 8);
        check("flush_err", err_double_free, 0);
        tick();
        check("post_flush_idx", alloc_index, 7);
        check("post_flush_valid", alloc_valid, 1);
        check("post_flush_err", err_double_free, 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            alloc_ready = ($urandom_range(0, 3) != 0);
            free_valid  = ($urandom_range(0, 2) == 0);
            free_index  = W'($urandom_range(0, N - 1));
            flush       = ($urandom_range(0, 150) == 0);
            tick();
        end
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        flush       = 1'b0;
        tick();
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
